// File: rtl/data_router_pkg.sv
// Shared definitions for the depthwise data router and its write-back path.
//
// Contents:
//   BANK_W / ROW_W / COL_W : output-buffer address field widths (2/2/28)
//   dwout_state_e          : dwout_writer FSM state encoding
//   beats_of()             : number of result beats that fill one buffer line
package data_router_pkg;

    localparam int BANK_W = 2;
    localparam int ROW_W  = 2;
    localparam int COL_W  = 28;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FLUSH   = 2'd1,
        DONE    = 2'd2
    } dwout_state_e;

    // A buffer line of bufw words is filled by bufw/pox result beats.
    function automatic int beats_of(input int bufw, input int pox);
        return bufw / pox;
    endfunction

endpackage

// File: rtl/line_packer.sv
// One buffer-line accumulator of the depthwise write-back path.
//
// Holds BUFW words. On load, the POX incoming pixels are written into slots
// [beat*POX +: POX]; clr zeroes the whole line so that slots not reached by a
// partial block are written out as 0.
//
// Build option: DWOUT_RELU_EN -- when defined, every captured pixel whose sign
// bit is set is stored as 0; when undefined pixels are stored unmodified.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture pix into the slot selected by beat
//   clr        : zero the accumulator (line has been written out)
//   beat       : beat index of the incoming pixels
//   pix        : POX signed pixels
//   acc        : registered accumulator contents
module line_packer
    import data_router_pkg::*;
#(
    parameter int DW     = 32,
    parameter int POX    = 16,
    parameter int BUFW   = 32,
    parameter int BEAT_W = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic                         clr,
    input  logic [BEAT_W-1:0]            beat,
    input  logic [POX-1:0][DW-1:0]       pix,
    output logic [BUFW-1:0][DW-1:0]      acc
);

    localparam int BEATS = beats_of(BUFW, POX);

    function automatic logic [DW-1:0] condition_pixel(input logic [DW-1:0] p);
`ifdef DWOUT_RELU_EN
        return p[DW-1] ? '0 : p;
`else
        return p;
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (load) begin
            // Constant slot indices per beat keep the write a plain decoder.
            for (int b = 0; b < BEATS; b++) begin
                if (beat == BEAT_W'(b)) begin
                    for (int x = 0; x < POX; x++) begin
                        acc[b*POX + x] <= condition_pixel(pix[x]);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dwout_writer.sv
// Depthwise write-back writer.
//
// Packs POY-row x POX-pixel result tiles from the depthwise PE array into
// BUFW-word buffer lines (one line per tile row / bank) and writes them to the
// output buffer with bank/row/col addressing. A blkend pulse flushes any
// partial line and produces a one-cycle blk_done.
//
// Build option: DWOUT_RELU_EN (see line_packer) clamps negative pixels to 0.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high (res_valid/res_ready, wr_en/wr_ready). A producer holds its
// valid and payload stable until the transfer; wr_* are held stable while
// wr_en && !wr_ready.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   res_valid/res_ready : result tile handshake, res_data = [POY][POX] pixels
//   blkend              : single-cycle end-of-block pulse
//   wr_en/wr_ready      : buffer write handshake
//   wr_bank/row/col     : write address, wr_data = one BUFW-word line
//   blk_done            : one-cycle pulse when a block is fully written
//   dbg_state           : current FSM state
module dwout_writer
    import data_router_pkg::*;
#(
    parameter int DW            = 32,
    parameter int POY           = 3,
    parameter int POX           = 16,
    parameter int BUFW          = 32,
    parameter int LINES_PER_ROW = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              res_valid,
    output logic                              res_ready,
    input  logic [POY-1:0][POX-1:0][DW-1:0]   res_data,
    input  logic                              blkend,
    output logic                              wr_en,
    input  logic                              wr_ready,
    output logic [BANK_W-1:0]                 wr_bank,
    output logic [ROW_W-1:0]                  wr_row,
    output logic [COL_W-1:0]                  wr_col,
    output logic [BUFW-1:0][DW-1:0]           wr_data,
    output logic                              blk_done,
    output dwout_state_e                      dbg_state
);

    localparam int BEATS  = beats_of(BUFW, POX);
    localparam int BEAT_W = $clog2(BEATS + 1);

    typedef logic [BUFW-1:0][DW-1:0] line_t;

    dwout_state_e          state;
    logic [BEAT_W-1:0]     beat;
    logic [BEAT_W-1:0]     beat_nxt;
    logic                  blk_pend;
    logic [BANK_W-1:0]     bank_q;
    logic [ROW_W-1:0]      row_q;
    logic [COL_W-1:0]      col_q;
    line_t                 lines [POY];

    logic                  load;
    logic                  accept;
    logic                  flush_last;
    logic                  pend;

    assign load       = res_valid && (state == COLLECT);
    assign accept     = (state == FLUSH) && wr_ready;
    assign flush_last = accept && (bank_q == BANK_W'(POY - 1));
    // A blkend arriving this cycle counts as pending immediately.
    assign pend       = blk_pend || blkend;
    assign beat_nxt   = beat + BEAT_W'(1);

    for (genvar g = 0; g < POY; g++) begin : g_pack
        line_packer #(
            .DW    (DW),
            .POX   (POX),
            .BUFW  (BUFW),
            .BEAT_W(BEAT_W)
        ) u_pack (
            .clk  (clk),
            .rst_n(rst_n),
            .load (load),
            .clr  (flush_last),
            .beat (beat),
            .pix  (res_data[g]),
            .acc  (lines[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= COLLECT;
            beat     <= '0;
            blk_pend <= 1'b0;
            bank_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            if (blkend) begin
                blk_pend <= 1'b1;
            end
            case (state)
                COLLECT: begin
                    if (load) begin
                        // The beat is captured even when blkend arrives with it.
                        beat <= beat_nxt;
                        if (beat_nxt == BEAT_W'(BEATS) || pend) begin
                            state <= FLUSH;
                        end
                    end else if (pend) begin
                        state <= (beat != '0) ? FLUSH : DONE;
                    end
                end
                FLUSH: begin
                    if (flush_last) begin
                        bank_q <= '0;
                        beat   <= '0;
                        if (col_q == COL_W'(LINES_PER_ROW - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + ROW_W'(1);
                        end else begin
                            col_q <= col_q + COL_W'(1);
                        end
                        state <= pend ? DONE : COLLECT;
                    end else if (accept) begin
                        bank_q <= bank_q + BANK_W'(1);
                    end
                end
                DONE: begin
                    row_q    <= '0;
                    col_q    <= '0;
                    // Only a blkend seen in this very cycle survives.
                    blk_pend <= blkend;
                    state    <= COLLECT;
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    assign res_ready = (state == COLLECT);
    assign wr_en     = (state == FLUSH);
    assign blk_done  = (state == DONE);
    assign wr_bank   = bank_q;
    assign wr_row    = row_q;
    assign wr_col    = col_q;
    assign dbg_state = state;

    always_comb begin
        wr_data = '0;
        for (int b = 0; b < POY; b++) begin
            if (bank_q == BANK_W'(b)) begin
                wr_data = lines[b];
            end
        end
    end

endmodule

// File: tb/tb_dwout_writer.sv
// Self-checking bench for dwout_writer. A line-level model predicts every
// buffer write (bank, row, col, data) and every blk_done from the tiles and
// blkend pulses driven; a monitor compares accepted writes against it, and
// directed literal checks pin reset values, latencies and address wrap.
module tb_dwout_writer;
    import data_router_pkg::*;

    localparam int DW    = 32;
    localparam int POY   = 3;
    localparam int POX   = 16;
    localparam int BUFW  = 32;
    localparam int LPR   = 4;
    localparam int BEATS = BUFW / POX;

    typedef logic [POY-1:0][POX-1:0][DW-1:0] tile_t;
    typedef logic [BUFW-1:0][DW-1:0]         line_t;
    typedef struct packed {
        logic        is_done;
        logic [1:0]  bank;
        logic [1:0]  row;
        logic [27:0] col;
        line_t       data;
    } exp_t;

    // ---------------- clock / reset / DUT ----------------
    logic         clk;
    logic         rst_n;
    logic         res_valid;
    logic         res_ready;
    tile_t        res_data;
    logic         blkend;
    logic         wr_en;
    logic         wr_ready;
    logic [1:0]   wr_bank;
    logic [1:0]   wr_row;
    logic [27:0]  wr_col;
    line_t        wr_data;
    logic         blk_done;
    dwout_state_e dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dwout_writer #(
        .DW(DW), .POY(POY), .POX(POX), .BUFW(BUFW), .LINES_PER_ROW(LPR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .blkend(blkend),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_bank(wr_bank),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .blk_done(blk_done), .dbg_state(dbg_state)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    exp_t  exp_q[$];
    line_t cur [POY];
    int    m_beat  = 0;
    int    line_no = 0;

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef DWOUT_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    task automatic model_clear();
        for (int y = 0; y < POY; y++) cur[y] = '0;
        m_beat = 0;
    endtask

    task automatic model_emit_line();
        exp_t e;
        for (int y = 0; y < POY; y++) begin
            e.is_done = 1'b0;
            e.bank    = 2'(y);
            e.row     = 2'((line_no / LPR) % 4);
            e.col     = 28'(line_no % LPR);
            e.data    = cur[y];
            exp_q.push_back(e);
        end
        line_no++;
        model_clear();
    endtask

    task automatic model_beat(input tile_t t);
        for (int y = 0; y < POY; y++)
            for (int x = 0; x < POX; x++)
                cur[y][m_beat*POX + x] = relu(t[y][x]);
        m_beat++;
        if (m_beat == BEATS) model_emit_line();
    endtask

    task automatic model_blkend();
        exp_t e;
        if (m_beat > 0) model_emit_line();
        e = '0;
        e.is_done = 1'b1;
        exp_q.push_back(e);
        line_no = 0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    int    wl_bank[$];
    int    wl_row[$];
    int    wl_col[$];
    line_t wl_data[$];
    logic        hold_prev = 1'b0;
    logic [1:0]  p_bank, p_row;
    logic [27:0] p_col;
    line_t       p_data;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_wr_bank", 64'(wr_bank), 64'(p_bank));
                chk("hold_wr_row",  64'(wr_row),  64'(p_row));
                chk("hold_wr_col",  64'(wr_col),  64'(p_col));
                checks++;
                if (wr_data !== p_data) begin
                    failures++;
                    $display("FAIL hold_wr_data changed while stalled");
                end
            end
            if (wr_en) chk("res_ready_in_flush", 64'(res_ready), 64'd0);
            if (wr_en && wr_ready) begin
                wl_bank.push_back(int'(wr_bank));
                wl_row.push_back(int'(wr_row));
                wl_col.push_back(int'(wr_col));
                wl_data.push_back(wr_data);
                checks++;
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    failures++;
                    $display("FAIL unexpected_write bank=%0d row=%0d col=%0d", wr_bank, wr_row, wr_col);
                end else begin
                    checks--;
                    e = exp_q.pop_front();
                    chk("wr_bank", 64'(wr_bank), 64'(e.bank));
                    chk("wr_row",  64'(wr_row),  64'(e.row));
                    chk("wr_col",  64'(wr_col),  64'(e.col));
                    checks++;
                    if (wr_data !== e.data) begin
                        failures++;
                        for (int k = 0; k < BUFW; k++) begin
                            if (wr_data[k] !== e.data[k]) begin
                                $display("FAIL wr_data bank=%0d word=%0d actual=%h expected=%h",
                                         wr_bank, k, wr_data[k], e.data[k]);
                                break;
                            end
                        end
                    end
                end
            end
            if (blk_done) begin
                checks++;
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    failures++;
                    $display("FAIL unexpected_blk_done pending=%0d", exp_q.size());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            hold_prev = wr_en && !wr_ready;
            p_bank = wr_bank; p_row = wr_row; p_col = wr_col; p_data = wr_data;
        end
    end

    // ---------------- driver tasks (start/end at posedge+1) ----------------
    function automatic tile_t pat(input int bt);
        tile_t t;
        for (int y = 0; y < POY; y++)
            for (int x = 0; x < POX; x++)
                t[y][x] = DW'(y*100 + bt*16 + x);
        return t;
    endfunction

    function automatic tile_t const_tile(input logic [DW-1:0] v);
        tile_t t;
        for (int y = 0; y < POY; y++)
            for (int x = 0; x < POX; x++)
                t[y][x] = v;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input tile_t t, input logic blk);
        int n = 0;
        while (!res_ready && n < 100) begin
            step();
            n++;
        end
        if (!res_ready) chk("res_ready_timeout", 64'd0, 64'd1);
        res_data  = t;
        res_valid = 1'b1;
        blkend    = blk;
        step();
        res_valid = 1'b0;
        blkend    = 1'b0;
        model_beat(t);
        if (blk) model_blkend();
    endtask

    task automatic send_blkend();
        blkend = 1'b1;
        step();
        blkend = 1'b0;
        model_blkend();
    endtask

    task automatic send_line(input int start);
        for (int b = 0; b < BEATS; b++) send_beat(pat(start + b), 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || wr_en) && n < 500) begin
            step();
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        step();
    endtask

    task automatic wait_bank(input logic [1:0] b);
        int n = 0;
        while (!(wr_en && wr_bank == b) && n < 50) begin
            step();
            n++;
        end
        chk("wait_bank_timeout", 64'(wr_en && wr_bank == b), 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int    n0;
        logic [DW-1:0] relu_exp;
        rst_n     = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        blkend    = 1'b0;
        wr_ready  = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res_ready", 64'(res_ready), 64'd1);
        chk("rst_wr_en",     64'(wr_en),     64'd0);
        chk("rst_wr_bank",   64'(wr_bank),   64'd0);
        chk("rst_wr_row",    64'(wr_row),    64'd0);
        chk("rst_wr_col",    64'(wr_col),    64'd0);
        chk("rst_wr_data",   64'(wr_data == '0), 64'd1);
        chk("rst_blk_done",  64'(blk_done),  64'd0);
        chk("rst_state",     64'(dbg_state), 64'(COLLECT));
        rst_n = 1'b1;
        step();

        // Basic line write: flush starts the cycle after the second beat.
        send_line(0);
        chk("first_write_wr_en",   64'(wr_en),   64'd1);
        chk("first_write_wr_bank", 64'(wr_bank), 64'd0);
        wait_idle();
        chk("basic_count", 64'(wl_bank.size()), 64'd3);
        chk("basic_bank2", 64'(wl_bank[2]), 64'd2);
        chk("basic_d0_16", 64'(wl_data[0][16]), 64'd16);
        chk("basic_d1_5",  64'(wl_data[1][5]),  64'd105);
        chk("basic_d2_31", 64'(wl_data[2][31]), 64'd231);

        // Write backpressure on bank 1.
        n0 = wl_bank.size();
        send_line(0);
        wait_bank(2'd1);
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_bank",      64'(wr_bank),    64'd1);
            chk("bp_res_ready", 64'(res_ready),  64'd0);
            chk("bp_data7",     64'(wr_data[7]), 64'd107);
        end
        wr_ready = 1'b1;
        wait_idle();
        chk("bp_count", 64'(wl_bank.size() - n0), 64'd3);
        chk("bp_col",   64'(wl_col[n0]), 64'd1);

        // Partial flush: one beat of 7 then blkend.
        n0 = wl_bank.size();
        send_beat(const_tile(32'd7), 1'b0);
        send_blkend();
        wait_bank(2'd2);
        step();
        chk("partial_blk_done", 64'(blk_done), 64'd1);
        wait_idle();
        chk("partial_w0",  64'(wl_data[n0+2][0]),  64'd7);
        chk("partial_w15", 64'(wl_data[n0+2][15]), 64'd7);
        chk("partial_w16", 64'(wl_data[n0+2][16]), 64'd0);
        chk("partial_w31", 64'(wl_data[n0+2][31]), 64'd0);
        n0 = wl_bank.size();
        send_line(4);
        wait_idle();
        chk("after_done_row", 64'(wl_row[n0]), 64'd0);
        chk("after_done_col", 64'(wl_col[n0]), 64'd0);

        // blkend with no beat collected: blk_done the next cycle, then gone.
        send_blkend();
        chk("idle_blk_done", 64'(blk_done), 64'd1);
        step();
        chk("idle_blk_done_off", 64'(blk_done), 64'd0);

        // Address wrap over 17 lines.
        n0 = wl_bank.size();
        for (int l = 0; l < 17; l++) send_line(l);
        wait_idle();
        chk("wrap_count", 64'(wl_bank.size() - n0), 64'd51);
        chk("wrap_l4_row",  64'(wl_row[n0+12]), 64'd1);
        chk("wrap_l4_col",  64'(wl_col[n0+12]), 64'd0);
        chk("wrap_l15_row", 64'(wl_row[n0+45]), 64'd3);
        chk("wrap_l15_col", 64'(wl_col[n0+45]), 64'd3);
        chk("wrap_l16_row", 64'(wl_row[n0+48]), 64'd0);
        chk("wrap_l16_col", 64'(wl_col[n0+48]), 64'd0);

        // blkend together with the final beat: beat captured, then done.
        send_beat(pat(2), 1'b0);
        send_beat(pat(3), 1'b1);
        wait_idle();

        // ReLU option.
        n0 = wl_bank.size();
        send_beat(const_tile(32'hFFFF_FFFB), 1'b0);
        send_blkend();
        wait_idle();
`ifdef DWOUT_RELU_EN
        relu_exp = 32'd0;
`else
        relu_exp = 32'hFFFF_FFFB;
`endif
        chk("relu_w0",  64'(wl_data[n0][0]),  64'(relu_exp));
        chk("relu_w16", 64'(wl_data[n0][16]), 64'd0);

        // Reset during the bank-1 write.
        send_line(0);
        wait_bank(2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_en",     64'(wr_en),     64'd0);
        chk("rst_mid_wr_bank",   64'(wr_bank),   64'd0);
        chk("rst_mid_res_ready", 64'(res_ready), 64'd1);
        exp_q.delete();
        model_clear();
        line_no = 0;
        step();
        rst_n = 1'b1;
        step();
        n0 = wl_bank.size();
        send_line(6);
        wait_idle();
        chk("post_rst_count", 64'(wl_bank.size() - n0), 64'd3);
        chk("post_rst_bank",  64'(wl_bank[n0]), 64'd0);
        chk("post_rst_row",   64'(wl_row[n0]),  64'd0);
        chk("post_rst_col",   64'(wl_col[n0]),  64'd0);
        chk("post_rst_d3",    64'(wl_data[n0][3]), 64'd99);

        repeat (3) step();
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
